// File: rtl/pkt_fifo_sram_pkg.sv
// rtl/pkt_fifo_sram_pkg.sv - shared sizing helpers and RAM word layout for pkt_fifo_sram
package pkt_fifo_sram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 3072;

    // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int calc_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int word_width(input int data_width);
        return data_width + 1;
    endfunction

    // RAM word is {last, data}; the last flag sits just above the payload.
    function automatic int last_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/sdp_ram_reg.sv
// rtl/sdp_ram_reg.sv - simple dual-port RAM, independent write port and registered read port
module sdp_ram_reg #(
    parameter int  WIDTH  = 9,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pkt_fifo_sram.sv
// rtl/pkt_fifo_sram.sv - store-and-forward packet FIFO with drop-on-error/overflow rewind
module pkt_fifo_sram
    import pkt_fifo_sram_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    localparam int CNT_WIDTH  = calc_cnt_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_wr_err,
    output logic                  o_wr_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    input  logic                  i_rd_ready,
    output logic [CNT_WIDTH-1:0]  o_used,
    output logic [CNT_WIDTH-1:0]  o_pkt_count,
    output logic                  o_drop
);

    localparam int                   PTR_W   = $clog2(DEPTH);
    localparam int                   WORD_W  = word_width(DATA_WIDTH);
    localparam int                   LAST_B  = last_bit(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_W-1:0]     PTR_MAX = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_used, r_open_cnt, r_avail, r_pkt_count;
    logic                 r_ovf, r_drop, r_inflight;
    logic                 r_out_valid, r_skid_valid;
    logic [WORD_W-1:0]    r_out_word, r_skid_word;

    logic                 w_wr_acc, w_room, w_wr_en, w_ovf, w_end, w_commit, w_dropping;
    logic                 w_hs, w_fetch;
    logic [1:0]           w_occ;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [WORD_W-1:0]    w_ram_q;

    assign o_wr_ready   = ~i_rst;
    assign w_wr_acc     = i_wr_valid & o_wr_ready;
    assign w_room       = (r_used < DEPTH_C) & ~r_ovf;
    assign w_wr_en      = w_wr_acc & w_room;
    assign w_ovf        = r_ovf | (w_wr_acc & ~w_room);
    assign w_end        = w_wr_acc & i_wr_last;
    assign w_commit     = w_end & ~i_wr_err & ~w_ovf;
    assign w_dropping   = w_end & ~w_commit;
    assign w_wr_ptr_nxt = w_wr_en ? ptr_inc(r_wr_ptr) : r_wr_ptr;

    // Occupancy seen by the fetch logic counts a beat leaving this cycle as already gone,
    // which is what lets the two-entry buffer stream at one beat per cycle.
    assign w_hs    = r_out_valid & i_rd_ready;
    assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight} - {1'b0, w_hs};
    assign w_fetch = (r_avail != '0) & (w_occ < 2'd2);

    sdp_ram_reg #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en & ~w_dropping),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({i_wr_last, i_wr_data}),
        .i_rd_en   (w_fetch),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_used       <= '0;
            r_open_cnt   <= '0;
            r_avail      <= '0;
            r_pkt_count  <= '0;
            r_ovf        <= 1'b0;
            r_drop       <= 1'b0;
            r_inflight   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_word  <= '0;
        end else begin
            r_wr_ptr <= w_dropping ? r_commit_ptr : w_wr_ptr_nxt;
            if (w_commit) begin
                r_commit_ptr <= w_wr_ptr_nxt;
            end
            if (w_end) begin
                r_open_cnt <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_open_cnt <= r_open_cnt + CNT_WIDTH'(1);
                end
                if (w_wr_acc && !w_room) begin
                    r_ovf <= 1'b1;
                end
            end
            r_drop  <= w_dropping;
            r_used  <= r_used + CNT_WIDTH'(w_wr_en && !w_dropping) - CNT_WIDTH'(w_hs)
                       - (w_dropping ? r_open_cnt : '0);
            // Readable words are tracked by count so a fully committed RAM is not mistaken for empty.
            r_avail <= r_avail + (w_commit ? r_open_cnt + CNT_WIDTH'(1) : '0) - CNT_WIDTH'(w_fetch);
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(w_commit)
                           - CNT_WIDTH'(w_hs && r_out_word[LAST_B]);

            if (w_fetch) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_inflight <= w_fetch;

            if (!r_out_valid || w_hs) begin
                if (r_skid_valid) begin
                    r_out_word   <= r_skid_word;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= r_inflight;
                    if (r_inflight) begin
                        r_skid_word <= w_ram_q;
                    end
                end else if (r_inflight) begin
                    r_out_word  <= w_ram_q;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (r_inflight) begin
                r_skid_word  <= w_ram_q;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_rd_valid  = r_out_valid;
    assign o_rd_data   = r_out_word[DATA_WIDTH-1:0];
    assign o_rd_last   = r_out_word[LAST_B];
    assign o_used      = r_used;
    assign o_pkt_count = r_pkt_count;
    assign o_drop      = r_drop;

endmodule

// File: tb/tb_pkt_fifo_sram.sv
// tb/tb_pkt_fifo_sram.sv - directed self-checking bench for pkt_fifo_sram (DEPTH=8 and DEPTH=6 instances)
module tb_pkt_fifo_sram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       wr_err = 1'b0;
    logic       rd_ready = 1'b0;
    logic       sel = 1'b0;

    logic       a_wr_ready, a_rd_valid, a_rd_last, a_drop;
    logic [7:0] a_rd_data;
    logic [3:0] a_used, a_pkt;
    logic       b_wr_ready, b_rd_valid, b_rd_last, b_drop;
    logic [7:0] b_rd_data;
    logic [2:0] b_used, b_pkt;

    logic       ob_wr_ready, ob_valid, ob_last, ob_drop;
    logic [7:0] ob_data, ob_used, ob_pkt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pkt_fifo_sram #(.DATA_WIDTH(8), .DEPTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .i_wr_last(wr_last), .i_wr_err(wr_err), .o_wr_ready(a_wr_ready),
        .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data), .o_rd_last(a_rd_last),
        .i_rd_ready(rd_ready), .o_used(a_used), .o_pkt_count(a_pkt), .o_drop(a_drop)
    );

    pkt_fifo_sram #(.DATA_WIDTH(8), .DEPTH(6)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
        .i_wr_last(wr_last), .i_wr_err(wr_err), .o_wr_ready(b_wr_ready),
        .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .o_rd_last(b_rd_last),
        .i_rd_ready(rd_ready), .o_used(b_used), .o_pkt_count(b_pkt), .o_drop(b_drop)
    );

    assign ob_wr_ready = sel ? b_wr_ready : a_wr_ready;
    assign ob_valid    = sel ? b_rd_valid : a_rd_valid;
    assign ob_data     = sel ? b_rd_data  : a_rd_data;
    assign ob_last     = sel ? b_rd_last  : a_rd_last;
    assign ob_drop     = sel ? b_drop     : a_drop;
    assign ob_used     = sel ? 8'(b_used) : 8'(a_used);
    assign ob_pkt      = sel ? 8'(b_pkt)  : 8'(a_pkt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_beat(input logic [7:0] d, input logic last, input logic err);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        wr_err   = err;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_err   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!ob_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, ob_valid, 1);
    endtask

    initial begin
        int sent = 0;
        int rx = 0;
        int cyc = 0;
        int drops = 0;
        logic held = 1'b0;
        logic [8:0] exp_w;

        // reset state
        tick();
        chk("rst_outs", {ob_valid, ob_data, ob_last, ob_used, ob_pkt, ob_drop, ob_wr_ready}, 0);
        rst = 1'b0;
        tick();
        chk("rst_wr_ready", ob_wr_ready, 1);
        chk("rst_used", ob_used, 0);

        // test 1: reset mid-traffic
        wr_beat(8'h55, 1'b0, 1'b0);
        wr_beat(8'h56, 1'b1, 1'b0);
        tick();
        tick();
        chk("t1_pre_word", {ob_valid, ob_last, ob_data}, {2'b10, 8'h55});
        tick();
        chk("t1_pre_hold", {ob_valid, ob_last, ob_data}, {2'b10, 8'h55});
        wr_valid = 1'b1;
        wr_data  = 8'h57;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_in_rst", {ob_valid, ob_data, ob_last, ob_used, ob_pkt, ob_drop, ob_wr_ready}, 0);
        end
        rst      = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("t1_rel_ready", ob_wr_ready, 1);
        chk("t1_rel_used", ob_used, 0);
        repeat (3) tick();
        chk("t1_no_stale", {ob_valid, ob_used, ob_pkt}, 0);

        // test 2: basic packet, latency and streaming
        rd_ready = 1'b1;
        wr_beat(8'h11, 1'b0, 1'b0);
        wr_beat(8'h12, 1'b0, 1'b0);
        wr_beat(8'h13, 1'b0, 1'b0);
        wr_beat(8'h14, 1'b1, 1'b0);
        chk("t2_used_4", ob_used, 4);
        chk("t2_pkt_1", ob_pkt, 1);
        chk("t2_valid_e0", ob_valid, 0);
        tick();
        chk("t2_valid_e1", ob_valid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_word", {ob_valid, ob_last, ob_data}, {1'b1, (i == 3), 8'(8'h11 + i)});
            chk("t2_used", ob_used, 4 - i);
            chk("t2_pkt", ob_pkt, 1);
            tick();
        end
        chk("t2_end", {ob_valid, ob_used, ob_pkt}, 0);

        // test 3: errored packet is dropped, next packet intact
        wr_beat(8'h31, 1'b0, 1'b0);
        chk("t3_used_1", {ob_used, ob_drop}, {8'd1, 1'b0});
        wr_beat(8'h32, 1'b0, 1'b0);
        chk("t3_used_2", {ob_used, ob_drop}, {8'd2, 1'b0});
        wr_beat(8'h33, 1'b1, 1'b1);
        chk("t3_drop", {ob_used, ob_drop}, {8'd0, 1'b1});
        tick();
        chk("t3_drop_once", {ob_drop, ob_valid, ob_pkt}, 0);
        wr_beat(8'hA0, 1'b0, 1'b0);
        wr_beat(8'hA1, 1'b1, 1'b0);
        tick();
        tick();
        chk("t3_a0", {ob_valid, ob_last, ob_data}, {2'b10, 8'hA0});
        tick();
        chk("t3_a1", {ob_valid, ob_last, ob_data}, {2'b11, 8'hA1});
        tick();
        chk("t3_end", {ob_valid, ob_used}, 0);

        // test 4: overflow drop on DEPTH=8, then exact fill
        for (int i = 0; i < 10; i++) begin
            wr_beat(8'(8'h40 + i), (i == 9), 1'b0);
            if (i == 7) chk("t4_used_full", ob_used, 8);
            if (i == 8) chk("t4_used_ovf", {ob_used, ob_drop}, {8'd8, 1'b0});
        end
        chk("t4_ovf_drop", {ob_used, ob_drop}, {8'd0, 1'b1});
        tick();
        chk("t4_nothing", {ob_valid, ob_pkt, ob_drop}, 0);
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_beat(8'(8'h80 + i), (i == 7), 1'b0);
        end
        chk("t4_fit", {ob_used, ob_pkt, ob_drop}, {8'd8, 8'd1, 1'b0});
        repeat (3) tick();
        chk("t4_head", {ob_valid, ob_last, ob_data, ob_used}, {2'b10, 8'h80, 8'd8});
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_word", {ob_valid, ob_last, ob_data}, {1'b1, (i == 7), 8'(8'h80 + i)});
            tick();
        end
        chk("t4_end", {ob_valid, ob_used, ob_pkt}, 0);

        // test 6: simultaneous commit/output-last and write/read
        rd_ready = 1'b0;
        wr_beat(8'h61, 1'b1, 1'b0);
        tick();
        tick();
        chk("t6_p1", {ob_valid, ob_last, ob_data, ob_pkt}, {2'b11, 8'h61, 8'd1});
        wr_beat(8'h62, 1'b0, 1'b0);
        chk("t6_used_pre", ob_used, 2);
        wr_valid = 1'b1;
        wr_data  = 8'h63;
        wr_last  = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("t6_pkt_same", ob_pkt, 1);
        chk("t6_used_same", ob_used, 2);
        wait_valid("t6_wait", 10);
        chk("t6_62", {ob_last, ob_data}, {1'b0, 8'h62});
        tick();
        chk("t6_63", {ob_valid, ob_last, ob_data}, {2'b11, 8'h63});
        tick();
        chk("t6_end", {ob_valid, ob_used, ob_pkt}, 0);

        // test 5: DEPTH=6, 20 packets of 4 beats, random backpressure, across wrap
        sel = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        while (rx < 80 && cyc < 3000) begin
            if (held) chk("t5_hold_valid", ob_valid, 1);
            if (ob_valid) begin
                exp_w = {(rx % 4 == 3), 8'(rx)};
                chk("t5_word", {ob_last, ob_data}, exp_w);
            end
            if (ob_drop) drops++;
            rd_ready = ($urandom_range(0, 3) != 0);
            if (ob_valid && rd_ready) rx++;
            held = ob_valid && !rd_ready;
            if (sent < 80 && (sent % 4 != 0 || ob_used <= 8'd2)) begin
                wr_valid = 1'b1;
                wr_data  = 8'(sent);
                wr_last  = (sent % 4 == 3);
                sent++;
            end else begin
                wr_valid = 1'b0;
                wr_last  = 1'b0;
            end
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("t5_rx_count", rx, 80);
        chk("t5_no_drops", drops, 0);
        tick();
        tick();
        chk("t5_end", {ob_valid, ob_used, ob_pkt}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
